// File: rtl/conv_pkg.sv
// Shared definitions for the convolution datapath: pixel width, the column
// feeder state encoding and a small width helper. Imported by the feeder,
// its address generator and the benches.
package conv_pkg;

  localparam int DATA_W = 8;

  // Column feeder FSM encoding (explicit values so other blocks can decode it).
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_X  = 3'd1,
    ST_RD_Y  = 3'd2,
    ST_RD_Z  = 3'd3,
    ST_CAP_Z = 3'd4,
    ST_VALID = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  // Which row of the current 3-row band is being addressed.
  typedef enum logic [1:0] {
    ROW_X = 2'd0,
    ROW_Y = 2'd1,
    ROW_Z = 2'd2
  } row_sel_t;

  // $clog2 that never returns 0, so a 1-entry counter still gets a 1-bit register.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// Column / band address generator for the column feeder.
// Keeps the column counter and the band base address (row band * IMG_W, built
// by repeated addition so no multiplier is needed) and forms the pixel address
// of the requested row of the current column.
// Ports:
//   i_clock      rising-edge clock
//   i_reset      synchronous reset, active-low
//   i_clear      restart at column 0 of band 0 (frame start)
//   i_advance    current column accepted; step to the next column / band
//   i_row_sel    row of the band being addressed (x, y or z)
//   o_addr       row-major pixel address: (band+row)*IMG_W + col
//   o_col_first  current column is column 0
//   o_band_last  current band is band IMG_H-3
//   o_last_col   current column is column IMG_W-1
module conv_addr_gen
  import conv_pkg::*;
#(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int ADDR_W = 6
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_clear,
  input  logic              i_advance,
  input  row_sel_t          i_row_sel,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_col_first,
  output logic              o_band_last,
  output logic              o_last_col
);

  localparam int COL_W = clog2_min1(IMG_W);

  localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] STEP2     = ADDR_W'(2 * IMG_W);
  localparam logic [ADDR_W-1:0] LAST_BASE = ADDR_W'((IMG_H - 3) * IMG_W);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(IMG_W - 1);

  logic [COL_W-1:0]  r_col;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] w_row_off;

  assign o_last_col  = (r_col == LAST_COL);
  assign o_col_first = (r_col == '0);
  // Band index is implied by the base address; compare against the last base.
  assign o_band_last = (r_base == LAST_BASE);

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_col  <= '0;
      r_base <= '0;
    end else if (i_clear) begin
      r_col  <= '0;
      r_base <= '0;
    end else if (i_advance) begin
      if (o_last_col) begin
        r_col <= '0;
        // On the final column of the final band the frame ends; hold the base.
        if (!o_band_last) r_base <= r_base + STEP;
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  always_comb begin
    w_row_off = '0;
    case (i_row_sel)
      ROW_X:   w_row_off = '0;
      ROW_Y:   w_row_off = STEP;
      ROW_Z:   w_row_off = STEP2;
      default: w_row_off = '0;
    endcase
  end

  assign o_addr = r_base + w_row_off + ADDR_W'(r_col);

endmodule

// File: rtl/conv_column_feeder.sv
// Streams a stored image to the convolution core as 3-pixel vertical columns.
// For every band (rows b, b+1, b+2) and every column c it reads the three
// pixels one per cycle, presents them on x/y/z with a valid/ready handshake
// and, after the last column of the last band is accepted, raises done.
// Ports:
//   i_clock       rising-edge clock
//   i_reset       synchronous reset, active-low
//   i_start       1-cycle pulse; begins a frame from IDLE or DONE
//   o_mem_ren     memory read enable
//   o_mem_addr    pixel address (row*IMG_W + col), 0 when not reading
//   i_mem_rdata   read data, valid one cycle after o_mem_ren
//   o_x/o_y/o_z   column pixels of rows band, band+1, band+2
//   o_col_valid   x/y/z hold a valid column
//   i_col_ready   consumer accepts when o_col_valid && i_col_ready
//   o_col_first   column 0 of a band (qualified by o_col_valid)
//   o_band_last   column of band IMG_H-3 (qualified by o_col_valid)
//   o_done        set once the last column is accepted, held until next start
module conv_column_feeder
  import conv_pkg::*;
#(
  parameter int DATA_W = conv_pkg::DATA_W,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int ADDR_W = 6
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_start,
  output logic              o_mem_ren,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [DATA_W-1:0] o_x,
  output logic [DATA_W-1:0] o_y,
  output logic [DATA_W-1:0] o_z,
  output logic              o_col_valid,
  input  logic              i_col_ready,
  output logic              o_col_first,
  output logic              o_band_last,
  output logic              o_done
);

  state_t            r_state;
  state_t            w_next;
  logic              w_mem_ren;
  row_sel_t          w_row_sel;
  logic              w_clear;
  logic              w_accept;

  logic [ADDR_W-1:0] w_addr;
  logic              w_col_first;
  logic              w_band_last;
  logic              w_last_col;

  logic [DATA_W-1:0] r_x;
  logic [DATA_W-1:0] r_y;
  logic [DATA_W-1:0] r_z;
  logic              r_col_valid;
  logic              r_done;

  conv_addr_gen #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_clear     (w_clear),
    .i_advance   (w_accept),
    .i_row_sel   (w_row_sel),
    .o_addr      (w_addr),
    .o_col_first (w_col_first),
    .o_band_last (w_band_last),
    .o_last_col  (w_last_col)
  );

  // State register
  always_ff @(posedge i_clock) begin
    if (!i_reset) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Next state and per-state controls
  always_comb begin
    w_next    = r_state;
    w_mem_ren = 1'b0;
    w_row_sel = ROW_X;
    w_clear   = 1'b0;
    w_accept  = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          w_clear = 1'b1;
          w_next  = ST_RD_X;
        end
      end
      ST_RD_X: begin
        w_mem_ren = 1'b1;
        w_row_sel = ROW_X;
        w_next    = ST_RD_Y;
      end
      ST_RD_Y: begin
        w_mem_ren = 1'b1;
        w_row_sel = ROW_Y;
        w_next    = ST_RD_Z;
      end
      ST_RD_Z: begin
        w_mem_ren = 1'b1;
        w_row_sel = ROW_Z;
        w_next    = ST_CAP_Z;
      end
      ST_CAP_Z: begin
        w_next = ST_VALID;
      end
      ST_VALID: begin
        if (i_col_ready) begin
          w_accept = 1'b1;
          w_next   = (w_last_col && w_band_last) ? ST_DONE : ST_RD_X;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Capture pipeline: each pixel arrives one cycle after its read, so x lands
  // in RD_Y, y in RD_Z and z in CAP_Z.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_x         <= '0;
      r_y         <= '0;
      r_z         <= '0;
      r_col_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      if (r_state == ST_RD_Y) r_x <= i_mem_rdata;
      if (r_state == ST_RD_Z) r_y <= i_mem_rdata;
      if (r_state == ST_CAP_Z) begin
        r_z         <= i_mem_rdata;
        r_col_valid <= 1'b1;
      end
      if (w_accept) r_col_valid <= 1'b0;
      if (w_clear)
        r_done <= 1'b0;
      else if (w_accept && w_last_col && w_band_last)
        r_done <= 1'b1;
    end
  end

  assign o_mem_ren   = w_mem_ren;
  assign o_mem_addr  = w_mem_ren ? w_addr : '0;
  assign o_x         = r_x;
  assign o_y         = r_y;
  assign o_z         = r_z;
  assign o_col_valid = r_col_valid;
  // Column position flags only mean something alongside a valid column.
  assign o_col_first = r_col_valid & w_col_first;
  assign o_band_last = r_col_valid & w_band_last;
  assign o_done      = r_done;

endmodule

// File: tb/tb_conv_column_feeder.sv
module tb_conv_column_feeder;

  localparam int AW   = 4;
  localparam int AH   = 4;
  localparam int AA   = 4;
  localparam int NCOL = AW * (AH - 2);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start_a, rdy_a, start_b, rdy_b;

  logic          ren_a, valid_a, first_a, last_a, done_a;
  logic [AA-1:0] addr_a;
  logic [7:0]    rdata_a, x_a, y_a, z_a;

  logic          ren_b, valid_b, first_b, last_b, done_b;
  logic [1:0]    addr_b;
  logic [7:0]    rdata_b, x_b, y_b, z_b;

  logic [7:0] mem_a [AW*AH];
  logic [7:0] mem_b [4];

  always @(posedge clk) if (ren_a) rdata_a <= mem_a[addr_a];
  always @(posedge clk) if (ren_b) rdata_b <= mem_b[addr_b];

  conv_column_feeder #(.DATA_W(8), .IMG_W(AW), .IMG_H(AH), .ADDR_W(AA)) dut_a (
    .i_clock(clk), .i_reset(rst_n), .i_start(start_a),
    .o_mem_ren(ren_a), .o_mem_addr(addr_a), .i_mem_rdata(rdata_a),
    .o_x(x_a), .o_y(y_a), .o_z(z_a),
    .o_col_valid(valid_a), .i_col_ready(rdy_a),
    .o_col_first(first_a), .o_band_last(last_a), .o_done(done_a)
  );

  conv_column_feeder #(.DATA_W(8), .IMG_W(1), .IMG_H(3), .ADDR_W(2)) dut_b (
    .i_clock(clk), .i_reset(rst_n), .i_start(start_b),
    .o_mem_ren(ren_b), .o_mem_addr(addr_b), .i_mem_rdata(rdata_b),
    .o_x(x_b), .o_y(y_b), .o_z(z_b),
    .o_col_valid(valid_b), .i_col_ready(rdy_b),
    .o_col_first(first_b), .o_band_last(last_b), .o_done(done_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Reference: column k of the frame is band k/AW, column k%AW; its pixels are
  // the three vertically stacked image pixels.
  logic [7:0] ex_x [NCOL], ex_y [NCOL], ex_z [NCOL];
  bit         ex_f [NCOL], ex_l [NCOL];

  task automatic build_ref();
    for (int b = 0; b < AH - 2; b++)
      for (int c = 0; c < AW; c++) begin
        ex_x[b*AW+c] = mem_a[b*AW+c];
        ex_y[b*AW+c] = mem_a[(b+1)*AW+c];
        ex_z[b*AW+c] = mem_a[(b+2)*AW+c];
        ex_f[b*AW+c] = (c == 0);
        ex_l[b*AW+c] = (b == AH - 3);
      end
  endtask

  // One full frame on dut_a. ready_pct: chance of accepting a valid column;
  // poke: throw start pulses at the busy feeder; hold2: stall column 2 for 10 cycles.
  task automatic run_frame(input int ready_pct, input bit poke, input bit hold2);
    int idx, cyc, last_ev, hold_cnt;
    bit prev_v;
    build_ref();
    idx = 0; cyc = 0; last_ev = 0; hold_cnt = 0; prev_v = 0;
    @(negedge clk);
    start_a = 1'b1;
    while (idx < NCOL && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      start_a = 1'b0;
      chk("done_low_in_frame", done_a, 0);
      if (valid_a) begin
        if (!prev_v) chk("valid_latency", cyc - last_ev, 5);
        chk("col_x", x_a, ex_x[idx]);
        chk("col_y", y_a, ex_y[idx]);
        chk("col_z", z_a, ex_z[idx]);
        chk("col_first", first_a, ex_f[idx]);
        chk("band_last", last_a, ex_l[idx]);
        chk("ren_while_valid", ren_a, 0);
        chk("addr_while_valid", addr_a, 0);
        if (poke && $urandom_range(3) == 0) start_a = 1'b1;
        rdy_a = ($urandom_range(99) < ready_pct);
        if (hold2 && idx == 2 && hold_cnt < 10) begin
          rdy_a = 1'b0;
          hold_cnt++;
        end
        if (rdy_a) begin
          idx++;
          last_ev = cyc;
        end
      end else begin
        if (poke && ren_a && $urandom_range(3) == 0) start_a = 1'b1;
        rdy_a = 1'($urandom_range(1));
      end
      prev_v = valid_a;
    end
    start_a = 1'b0;
    chk("frame_complete", idx, NCOL);
    @(negedge clk);
    rdy_a = 1'b0;
    chk("done_rise", done_a, 1);
    chk("valid_after_last", valid_a, 0);
    repeat (3) @(negedge clk);
    chk("done_held", done_a, 1);
    chk("ren_in_done", ren_a, 0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start_a = 1'b0; rdy_a = 1'b0; start_b = 1'b0; rdy_b = 1'b0;
    for (int i = 0; i < AW*AH; i++) mem_a[i] = 8'(i);
    mem_b[0] = 8'd9; mem_b[1] = 8'd8; mem_b[2] = 8'd7; mem_b[3] = 8'd0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_x", x_a, 0);
    chk("rst_y", y_a, 0);
    chk("rst_z", z_a, 0);
    chk("rst_valid", valid_a, 0);
    chk("rst_first", first_a, 0);
    chk("rst_last", last_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_ren", ren_a, 0);
    chk("rst_addr", addr_a, 0);
    chk("rst_b_done", done_b, 0);
    rst_n = 1'b1;

    // mem[i]=i frame, full throughput
    run_frame(100, 1'b0, 1'b0);
    // Restart from DONE with a 10-cycle stall on column 2
    run_frame(100, 1'b0, 1'b1);

    // Reset mid-frame during RD_Y of column 1 (address 1+AW), start held too
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0; rdy_a = 1'b1;
    n = 0;
    while (!(ren_a && addr_a == AA'(1 + AW)) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reached_rd_y_col1", n < 100, 1);
    rst_n = 1'b0; start_a = 1'b1;
    @(negedge clk);
    chk("midrst_ren", ren_a, 0);
    chk("midrst_addr", addr_a, 0);
    chk("midrst_valid", valid_a, 0);
    chk("midrst_xyz", {x_a, y_a, z_a}, 0);
    chk("midrst_done", done_a, 0);
    rst_n = 1'b1; start_a = 1'b0; rdy_a = 1'b0;
    @(negedge clk);
    chk("idle_after_rst", ren_a, 0);
    run_frame(100, 1'b0, 1'b0);

    // Start pulses while busy must not disturb the sequence
    run_frame(100, 1'b1, 1'b0);

    // Random image contents with random backpressure
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < AW*AH; i++) mem_a[i] = 8'($urandom);
      run_frame(20 + 25 * r, 1'b1, 1'b0);
    end

    // Degenerate 1x3 image: single column, both flags, then done
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    n = 0;
    while (!valid_b && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("b_valid_seen", valid_b, 1);
    chk("b_xyz", {x_b, y_b, z_b}, {8'd9, 8'd8, 8'd7});
    chk("b_first", first_b, 1);
    chk("b_last", last_b, 1);
    chk("b_done_before", done_b, 0);
    rdy_b = 1'b1;
    @(negedge clk);
    rdy_b = 1'b0;
    chk("b_done", done_b, 1);
    chk("b_valid_after", valid_b, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
